// File: rtl/jt51_wr_pkg.sv
// Shared definitions for the JT51 CPU write interface: register addresses,
// handshake states and the strobe-select decode for pipelined writes.
package jt51_wr_pkg;

    localparam logic [7:0] REG_TEST   = 8'h01;
    localparam logic [7:0] REG_KON    = 8'h08;
    localparam logic [7:0] REG_NOISE  = 8'h0F;
    localparam logic [7:0] REG_CLKA1  = 8'h10;
    localparam logic [7:0] REG_CLKA2  = 8'h11;
    localparam logic [7:0] REG_CLKB   = 8'h12;
    localparam logic [7:0] REG_TIMCTL = 8'h14;
    localparam logic [7:0] REG_LFRQ   = 8'h18;
    localparam logic [7:0] REG_PMDAMD = 8'h19;
    localparam logic [7:0] REG_CTW    = 8'h1B;

    typedef enum logic [1:0] {IDLE, REQ, ACK} hs_state_t;

    // Bit positions of the update strobes inside the strobe vector
    localparam int NUM_UP   = 11;
    localparam int UP_RL    = 0;
    localparam int UP_KC    = 1;
    localparam int UP_KF    = 2;
    localparam int UP_PMS   = 3;
    localparam int UP_DT1   = 4;
    localparam int UP_TL    = 5;
    localparam int UP_KS    = 6;
    localparam int UP_AMSEN = 7;
    localparam int UP_DT2   = 8;
    localparam int UP_D1L   = 9;
    localparam int UP_KEYON = 10;

    function automatic logic is_pipelined(input logic [7:0] addr);
        return (addr == REG_KON) || (addr >= 8'h20);
    endfunction

    function automatic logic [NUM_UP-1:0] up_decode(input logic [7:0] addr);
        logic [NUM_UP-1:0] sel;
        sel = '0;
        if (addr == REG_KON) begin
            sel[UP_KEYON] = 1'b1;
        end else begin
            case (addr[7:5])
                3'd1:    sel[addr[4:3]] = 1'b1;   // RL/KC/KF/PMS share 0x20-0x3F
                3'd2:    sel[UP_DT1]    = 1'b1;
                3'd3:    sel[UP_TL]     = 1'b1;
                3'd4:    sel[UP_KS]     = 1'b1;
                3'd5:    sel[UP_AMSEN]  = 1'b1;
                3'd6:    sel[UP_DT2]    = 1'b1;
                3'd7:    sel[UP_D1L]    = 1'b1;
                default: sel = '0;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/jt51_wr_hs.sv
// Request/acknowledge handshake with the register file: holds the selected
// update strobe and busy until the register file finishes its sweep.
module jt51_wr_hs
    import jt51_wr_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              start,
    input  logic [NUM_UP-1:0] up_sel,
    input  logic              reg_busy,
    output logic [NUM_UP-1:0] up,
    output logic              busy
);

    hs_state_t         state_reg, state_next;
    logic [NUM_UP-1:0] up_reg, up_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            up_reg    <= '0;
        end else begin
            state_reg <= state_next;
            up_reg    <= up_next;
        end
    end

    // Leaving IDLE ignores cen so busy rises on the same edge as the capture
    always_comb begin
        state_next = state_reg;
        up_next    = up_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                    up_next    = up_sel;
                end
            end
            REQ: begin
                if (cen && reg_busy) state_next = ACK;
            end
            ACK: begin
                if (cen && !reg_busy) begin
                    state_next = IDLE;
                    up_next    = '0;
                end
            end
            default: begin
                state_next = IDLE;
                up_next    = '0;
            end
        endcase
    end

    assign up   = up_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: rtl/jt51_wr_if.sv
// JT51 CPU write port: latches address/data writes, keeps the global registers
// and forwards per-channel/operator writes to the register file.
module jt51_wr_if
    import jt51_wr_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       cs_n,
    input  logic       wr_n,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       reg_busy,
    input  logic       flag_a,
    input  logic       flag_b,
    output logic [7:0] d_in,
    output logic [1:0] op,
    output logic [2:0] ch,
    output logic       up_rl,
    output logic       up_kc,
    output logic       up_kf,
    output logic       up_pms,
    output logic       up_dt1,
    output logic       up_tl,
    output logic       up_ks,
    output logic       up_amsen,
    output logic       up_dt2,
    output logic       up_d1l,
    output logic       up_keyon,
    output logic       busy,
    output logic [7:0] test,
    output logic       ne,
    output logic [4:0] nfrq,
    output logic [9:0] value_a,
    output logic [7:0] value_b,
    output logic       csm,
    output logic       irqen_b,
    output logic       irqen_a,
    output logic       load_b,
    output logic       load_a,
    output logic       clr_flag_b,
    output logic       clr_flag_a,
    output logic [7:0] lfo_freq,
    output logic [6:0] amd,
    output logic [6:0] pmd,
    output logic       ct1,
    output logic       ct2,
    output logic [1:0] lfo_w
);

    logic              we, we_reg, wr_event;
    logic [7:0]        addr_reg;
    logic              data_event, pipe_addr, accept, global_wr;
    logic [NUM_UP-1:0] up_vec;

    assign we         = !cs_n && !wr_n;
    assign wr_event   = we && !we_reg;
    assign data_event = wr_event && a0;
    assign pipe_addr  = is_pipelined(addr_reg);
    assign accept     = data_event && pipe_addr && !busy;
    assign global_wr  = data_event && !pipe_addr;

    jt51_wr_hs u_hs (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .start    (accept),
        .up_sel   (up_decode(addr_reg)),
        .reg_busy (reg_busy),
        .up       (up_vec),
        .busy     (busy)
    );

    assign up_rl    = up_vec[UP_RL];
    assign up_kc    = up_vec[UP_KC];
    assign up_kf    = up_vec[UP_KF];
    assign up_pms   = up_vec[UP_PMS];
    assign up_dt1   = up_vec[UP_DT1];
    assign up_tl    = up_vec[UP_TL];
    assign up_ks    = up_vec[UP_KS];
    assign up_amsen = up_vec[UP_AMSEN];
    assign up_dt2   = up_vec[UP_DT2];
    assign up_d1l   = up_vec[UP_D1L];
    assign up_keyon = up_vec[UP_KEYON];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg   <= 1'b0;
            addr_reg <= 8'h00;
            dout     <= 8'h00;
        end else begin
            we_reg <= we;
            dout   <= {busy, 5'b0, flag_b, flag_a};
            if (wr_event && !a0) addr_reg <= din;
        end
    end

    // Operands for the register file stay put until the next accepted write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_in <= 8'h00;
            op   <= 2'd0;
            ch   <= 3'd0;
        end else if (accept) begin
            d_in <= din;
            op   <= addr_reg[4:3];
            ch   <= addr_reg[2:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            test       <= 8'h00;
            ne         <= 1'b0;
            nfrq       <= 5'd0;
            value_a    <= 10'd0;
            value_b    <= 8'h00;
            csm        <= 1'b0;
            irqen_b    <= 1'b0;
            irqen_a    <= 1'b0;
            load_b     <= 1'b0;
            load_a     <= 1'b0;
            clr_flag_b <= 1'b0;
            clr_flag_a <= 1'b0;
            lfo_freq   <= 8'h00;
            amd        <= 7'd0;
            pmd        <= 7'd0;
            ct1        <= 1'b0;
            ct2        <= 1'b0;
            lfo_w      <= 2'd0;
        end else begin
            clr_flag_b <= 1'b0;
            clr_flag_a <= 1'b0;
            if (global_wr) begin
                case (addr_reg)
                    REG_TEST:  test <= din;
                    REG_NOISE: begin
                        ne   <= din[7];
                        nfrq <= din[4:0];
                    end
                    REG_CLKA1: value_a[9:2] <= din;
                    REG_CLKA2: value_a[1:0] <= din[1:0];
                    REG_CLKB:  value_b <= din;
                    REG_TIMCTL: begin
                        csm        <= din[7];
                        clr_flag_b <= din[5];
                        clr_flag_a <= din[4];
                        irqen_b    <= din[3];
                        irqen_a    <= din[2];
                        load_b     <= din[1];
                        load_a     <= din[0];
                    end
                    REG_LFRQ:  lfo_freq <= din;
                    REG_PMDAMD: begin
                        if (din[7]) pmd <= din[6:0];
                        else        amd <= din[6:0];
                    end
                    REG_CTW: begin
                        ct1   <= din[7];
                        ct2   <= din[6];
                        lfo_w <= din[1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt51_wr_if.sv
// Randomized scoreboard bench for jt51_wr_if with a register-file responder.
module tb_jt51_wr_if;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       cs_n = 1'b1;
    logic       wr_n = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       reg_busy = 1'b0;
    logic       flag_a = 1'b0;
    logic       flag_b = 1'b0;
    logic [7:0] dout, d_in, test, value_b, lfo_freq;
    logic [1:0] op, lfo_w;
    logic [2:0] ch;
    logic       up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon;
    logic       busy, ne, csm, irqen_b, irqen_a, load_b, load_a, clr_flag_b, clr_flag_a, ct1, ct2;
    logic [4:0] nfrq;
    logic [9:0] value_a;
    logic [6:0] amd, pmd;

    jt51_wr_if dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .din(din),
        .dout(dout), .reg_busy(reg_busy), .flag_a(flag_a), .flag_b(flag_b),
        .d_in(d_in), .op(op), .ch(ch),
        .up_rl(up_rl), .up_kc(up_kc), .up_kf(up_kf), .up_pms(up_pms), .up_dt1(up_dt1),
        .up_tl(up_tl), .up_ks(up_ks), .up_amsen(up_amsen), .up_dt2(up_dt2), .up_d1l(up_d1l),
        .up_keyon(up_keyon), .busy(busy), .test(test), .ne(ne), .nfrq(nfrq),
        .value_a(value_a), .value_b(value_b), .csm(csm), .irqen_b(irqen_b), .irqen_a(irqen_a),
        .load_b(load_b), .load_a(load_a), .clr_flag_b(clr_flag_b), .clr_flag_a(clr_flag_a),
        .lfo_freq(lfo_freq), .amd(amd), .pmd(pmd), .ct1(ct1), .ct2(ct2), .lfo_w(lfo_w)
    );

    always #5 clk = ~clk;

    // Strobe order used by the bench: 0 rl .. 9 d1l, 10 keyon
    logic [10:0] up_vec;
    logic [62:0] dut_globals;
    assign up_vec = {up_keyon, up_d1l, up_dt2, up_amsen, up_ks, up_tl, up_dt1, up_pms, up_kf, up_kc, up_rl};
    assign dut_globals = {test, ne, nfrq, value_a, value_b, csm, irqen_b, irqen_a, load_b, load_a,
                          lfo_freq, amd, pmd, ct1, ct2, lfo_w};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [10:0] up; logic [7:0] d; logic [1:0] op; logic [2:0] ch; } pexp_t;
    pexp_t      exp_q[$];
    logic [1:0] clr_q[$];

    logic [7:0] m_addr, m_test, m_value_b, m_lfo_freq, m_dout;
    logic       m_ne, m_csm, m_irqen_b, m_irqen_a, m_load_b, m_load_a, m_ct1, m_ct2;
    logic [4:0] m_nfrq;
    logic [9:0] m_value_a;
    logic [6:0] m_amd, m_pmd;
    logic [1:0] m_lfo_w;
    logic       m_pending, m_acked, m_we_prev;

    function automatic logic [62:0] m_globals();
        return {m_test, m_ne, m_nfrq, m_value_a, m_value_b, m_csm, m_irqen_b, m_irqen_a, m_load_b,
                m_load_a, m_lfo_freq, m_amd, m_pmd, m_ct1, m_ct2, m_lfo_w};
    endfunction

    // Which update strobe an address selects; -1 for global/undefined addresses
    function automatic int strobe_of(input logic [7:0] a);
        if (a == 8'h08) return 10;
        if (a < 8'h20)  return -1;
        if (a < 8'h28)  return 0;
        if (a < 8'h30)  return 1;
        if (a < 8'h38)  return 2;
        if (a < 8'h40)  return 3;
        if (a < 8'h60)  return 4;
        if (a < 8'h80)  return 5;
        if (a < 8'hA0)  return 6;
        if (a < 8'hC0)  return 7;
        if (a < 8'hE0)  return 8;
        return 9;
    endfunction

    task automatic model_reset();
        {m_addr, m_test, m_value_b, m_lfo_freq, m_dout} = '0;
        {m_ne, m_csm, m_irqen_b, m_irqen_a, m_load_b, m_load_a, m_ct1, m_ct2} = '0;
        m_nfrq = '0; m_value_a = '0; m_amd = '0; m_pmd = '0; m_lfo_w = '0;
        m_pending = 1'b0; m_acked = 1'b0; m_we_prev = 1'b0;
        exp_q.delete();
        clr_q.delete();
    endtask

    task automatic model_data(input logic [7:0] d, input logic was_pending);
        int idx;
        pexp_t e;
        idx = strobe_of(m_addr);
        if (idx >= 0) begin
            if (!was_pending) begin
                e.up = 11'd1 << idx; e.d = d; e.op = m_addr[4:3]; e.ch = m_addr[2:0];
                exp_q.push_back(e);
                m_pending = 1'b1;
                m_acked   = 1'b0;
            end
        end else begin
            case (m_addr)
                8'h01: m_test = d;
                8'h0F: begin m_ne = d[7]; m_nfrq = d[4:0]; end
                8'h10: m_value_a = {d, m_value_a[1:0]};
                8'h11: m_value_a = {m_value_a[9:2], d[1:0]};
                8'h12: m_value_b = d;
                8'h14: begin
                    m_csm = d[7]; m_irqen_b = d[3]; m_irqen_a = d[2]; m_load_b = d[1]; m_load_a = d[0];
                    if (d[5] || d[4]) clr_q.push_back(d[5:4]);
                end
                8'h18: m_lfo_freq = d;
                8'h19: if (d[7]) m_pmd = d[6:0]; else m_amd = d[6:0];
                8'h1B: begin m_ct1 = d[7]; m_ct2 = d[6]; m_lfo_w = d[1:0]; end
                default: ;
            endcase
        end
    endtask

    logic m_was_pending, m_we_now;
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst_n) begin
                m_was_pending = m_pending;
                m_dout        = {m_pending, 5'b0, flag_b, flag_a};
                m_we_now      = !cs_n && !wr_n;
                if (cen && m_pending) begin
                    if (!m_acked && reg_busy)     m_acked = 1'b1;
                    else if (m_acked && !reg_busy) begin m_pending = 1'b0; m_acked = 1'b0; end
                end
                if (m_we_now && !m_we_prev) begin
                    if (!a0) m_addr = din;
                    else     model_data(din, m_was_pending);
                end
                m_we_prev = m_we_now;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        mon_busy_prev = 1'b0;
    logic [23:0] mon_held;
    pexp_t       pe;
    logic [1:0]  ce;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("busy", 64'(busy), 64'(m_pending));
                chk("dout", 64'(dout), 64'(m_dout));
                chk("globals", 64'(dut_globals), 64'(m_globals()));
                if (busy && !mon_busy_prev) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL unexpected_write: strobes %0h d_in %0h with nothing expected", up_vec, d_in);
                    end else begin
                        pe = exp_q.pop_front();
                        chk("strobe", 64'(up_vec), 64'(pe.up));
                        chk("d_in", 64'(d_in), 64'(pe.d));
                        chk("op_ch", 64'({op, ch}), 64'({pe.op, pe.ch}));
                    end
                    mon_held = {up_vec, d_in, op, ch};
                end else if (busy) begin
                    chk("held", 64'({up_vec, d_in, op, ch}), 64'(mon_held));
                end else begin
                    chk("idle_strobes", 64'(up_vec), 64'd0);
                end
                if (clr_flag_a || clr_flag_b) begin
                    if (clr_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL clr_pulse: got %0b%0b expected none", clr_flag_b, clr_flag_a);
                    end else begin
                        ce = clr_q.pop_front();
                        chk("clr_pulse", 64'({clr_flag_b, clr_flag_a}), 64'(ce));
                    end
                end
            end
            mon_busy_prev = busy;
        end
    end

    // ---------------- register-file responder and cen ----------------
    int rb_fixed = 0;
    int rb_phase = 0;
    int rb_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rb_phase = 0;
                reg_busy = 1'b0;
            end else begin
                case (rb_phase)
                    0: if (|up_vec) begin
                        rb_cnt = (rb_fixed > 0) ? rb_fixed : int'($urandom_range(1, 6));
                        rb_phase = 1;
                    end
                    1: if (cen) begin
                        rb_cnt--;
                        if (rb_cnt == 0) begin
                            reg_busy = 1'b1;
                            rb_cnt = int'($urandom_range(1, 4));
                            rb_phase = 2;
                        end
                    end
                    2: if (cen) begin
                        rb_cnt--;
                        if (rb_cnt == 0) begin
                            reg_busy = 1'b0;
                            rb_phase = 3;
                        end
                    end
                    default: if (!(|up_vec)) rb_phase = 0;
                endcase
            end
            cen = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus_wr(input logic a, input logic [7:0] d, input int hold);
        @(negedge clk);
        a0 = a; din = d; cs_n = 1'b0; wr_n = 1'b0;
        repeat (hold) @(negedge clk);
        cs_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [7:0] d);
        bus_wr(1'b0, addr, 1);
        bus_wr(1'b1, d, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_pending && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_vec++; n_err++;
            $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'(up_vec), 64'd0);
        chk("rst_value_a", 64'(value_a), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_d_in", 64'({d_in, op, ch}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] glist [16] = '{8'h01, 8'h0F, 8'h10, 8'h11, 8'h12, 8'h14, 8'h18, 8'h19,
                               8'h1B, 8'h00, 8'h03, 8'h0A, 8'h13, 8'h16, 8'h1A, 8'h1F};
    int pulses;
    logic [7:0] ra;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_dout", 64'(dout), 64'd0);

        // Timer A split across two registers; no handshake involved
        wr_reg(8'h10, 8'hAB);
        wr_reg(8'h11, 8'h03);
        @(negedge clk);
        chk("value_a", 64'(value_a), 64'h2AF);
        chk("global_no_busy", 64'(busy), 64'd0);

        // Pipelined TL write, slow register file, dropped write while busy
        rb_fixed = 32;
        wr_reg(8'h6B, 8'h45);
        chk("tl_strobe", 64'(up_tl), 64'd1);
        chk("tl_opch", 64'({d_in, op, ch}), 64'({8'h45, 2'd1, 3'd3}));
        chk("tl_busy", 64'(busy), 64'd1);
        wr_reg(8'h28, 8'h7F);
        @(negedge clk);
        chk("drop_d_in", 64'(d_in), 64'h45);
        chk("drop_up_kc", 64'(up_kc), 64'd0);
        for (int i = 0; i < 3000 && !reg_busy; i++) @(negedge clk);
        @(negedge clk);
        chk("tl_held", 64'(up_tl), 64'd1);
        wait_idle();
        chk("tl_released", 64'({busy, up_tl}), 64'd0);
        bus_wr(1'b1, 8'h7F, 1);
        chk("kc_accept", 64'({up_kc, d_in}), 64'({1'b1, 8'h7F}));
        wait_idle();

        // Timer control: two clear pulses plus level bits
        wr_reg(8'h14, 8'h35);
        chk("clr_pulse_on", 64'({clr_flag_b, clr_flag_a}), 64'h3);
        @(negedge clk);
        chk("clr_pulse_off", 64'({clr_flag_b, clr_flag_a}), 64'h0);
        chk("timctl_levels", 64'({csm, irqen_b, irqen_a, load_b, load_a}), 64'b00101);

        // Status byte while a write is pending
        rb_fixed = 10;
        flag_a = 1'b1; flag_b = 1'b0;
        wr_reg(8'h30, 8'h12);
        @(negedge clk);
        chk("dout_status", 64'(dout), 64'h81);
        wait_idle();
        rb_fixed = 0;

        // Long strobe must produce a single event
        bus_wr(1'b0, 8'h14, 1);
        @(negedge clk);
        a0 = 1'b1; din = 8'h10; cs_n = 1'b0; wr_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 9) begin cs_n = 1'b1; wr_n = 1'b1; end
            if (clr_flag_a) pulses++;
        end
        chk("single_event", 64'(pulses), 64'd1);

        // Reset in the middle of a handshake
        rb_fixed = 20;
        wr_reg(8'h40, 8'h11);
        @(negedge clk);
        do_reset();
        rb_fixed = 0;

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 3))
                0: ra = glist[$urandom_range(0, 15)];
                1: ra = 8'(32 + $urandom_range(0, 223));
                2: ra = 8'h08;
                default: ra = 8'($urandom_range(0, 255));
            endcase
            flag_a = 1'($urandom_range(0, 1));
            flag_b = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) bus_wr(1'b0, ra, 1);
            else                           wr_reg(ra, 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 7) == 0) wait_idle();
        end

        wait_idle();
        repeat (4) @(negedge clk);
        chk("pending_left", 64'(exp_q.size()), 64'd0);
        chk("clr_left", 64'(clr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jt51_wr_if.md
Name: jt51_wr_if

Overview:
- CPU-side write interface and address decoder for JT51; sits directly upstream of the operator/channel register file.
- Latches the address/data bus writes and classifies each write as either global (timers, LFO, noise, test, CT) or per-channel/per-operator.
- Global registers are stored locally and updated at once.
- Per-channel/operator writes become held `up_*` strobes plus `d_in`/`op`/`ch`, presented to the register file until it completes its 32-slot busy sweep.
- Generates the CPU-visible busy and status byte.

Parameters:
- none

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low (one clock; async active-low reset fixed)
- cen  in  1  P1 clock enable, same as register file
- cs_n  in  1  chip select, active low
- wr_n  in  1  write strobe, active low
- a0  in  1  0 = address port, 1 = data port
- din  in  8  CPU data
- dout  out  8  status: {busy, 5'b0, flag_b, flag_a}
- reg_busy  in  1  busy from register file
- flag_a, flag_b  in  1 each  timer flags
- d_in  out  8  captured data for register file
- op  out  2  addr[4:3]
- ch  out  3  addr[2:0]
- up_rl, up_kc, up_kf, up_pms, up_dt1, up_tl, up_ks, up_amsen, up_dt2, up_d1l, up_keyon  out  1 each  held update strobes
- busy  out  1  write pending or in progress
- test  out  8  reg 0x01
- ne  out  1  reg 0x0F bit7
- nfrq  out  5  reg 0x0F bits4:0
- value_a  out  10  0x10 = bits9:2, 0x11 = bits1:0 from din[1:0]
- value_b  out  8  reg 0x12
- csm, irqen_b, irqen_a, load_b, load_a  out  1 each  reg 0x14 bits 7,3,2,1,0 (levels)
- clr_flag_b, clr_flag_a  out  1 each  reg 0x14 bits 5,4 (pulses)
- lfo_freq  out  8  reg 0x18
- amd, pmd  out  7 each  reg 0x19; din[7]=1 selects pmd, else amd
- ct1, ct2  out  1 each  reg 0x1B bits 7,6
- lfo_w  out  2  reg 0x1B bits 1:0

Behaviour:
- Write detect:
  - The block samples `we = !cs_n & !wr_n` every clk, not cen-gated.
  - A write event is the first clk where `we` rises (0 to 1); one event per strobe.
- Address event (a0=0): `addr <= din`, applied unconditionally, even while busy.
- Data event (a0=1), global address: the addressed register field updates on the next clk edge.
  - clr_flag_a/b become 1 for exactly one clk, then 0.
  - Undefined addresses (0x00, 0x02-0x07, 0x09-0x0E, 0x13, 0x15-0x17, 0x1A, 0x1C-0x1F) are ignored.
- Data event, pipelined address (0x08, 0x20-0xFF) with busy=0:
  - Capture d_in=din, op=addr[4:3], ch=addr[2:0].
  - Assert exactly one strobe, selected by address:
    - up_keyon: 0x08
    - up_rl: 0x20-27
    - up_kc: 0x28-2F
    - up_kf: 0x30-37
    - up_pms: 0x38-3F
    - up_dt1: 0x40-5F
    - up_tl: 0x60-7F
    - up_ks: 0x80-9F
    - up_amsen: 0xA0-BF
    - up_dt2: 0xC0-DF
    - up_d1l: 0xE0-FF
  - Set busy=1 on the same edge.
- Data event, pipelined address, busy=1: write dropped; no outputs change.
- Handshake FSM (transitions only on cen=1):
  - IDLE: strobes 0, busy 0; goes to REQ on an accepted pipelined write (the capture is cen-independent).
  - REQ: strobe held; reg_busy=1 goes to ACK.
  - ACK: strobe held; reg_busy=0 goes to IDLE, clearing the strobe and busy on that edge.
  - d_in/op/ch stay stable from capture until IDLE is re-entered.
- dout: registered every clk as {busy, 5'b0, flag_b, flag_a}.
- Reset values (rst_n low, asynchronous):
  - all strobes, busy, d_in, op, ch, addr, and all global fields = 0; FSM = IDLE; dout = 0.
  - Reset mid-transaction abandons the pending write.
- A simultaneous write event and ACK-to-IDLE transition count as busy=1: the write is dropped.

Decomposition:
- Package `jt51_wr_pkg`:
  - register address constants (REG_TEST=8'h01, REG_KON=8'h08, REG_NOISE=8'h0F, REG_CLKA1=8'h10, REG_CLKA2=8'h11, REG_CLKB=8'h12, REG_TIMCTL=8'h14, REG_LFRQ=8'h18, REG_PMDAMD=8'h19, REG_CTW=8'h1B)
  - FSM state enum {IDLE, REQ, ACK}.
- Sub-module `jt51_wr_hs`: the 3-state handshake FSM, holding the strobe vector and busy.
- Address decode and global registers stay in the top level.

Test Plan:
- Reset: hold rst_n=0 mid-REQ → busy=0, all up_*=0, value_a=0, FSM IDLE immediately without clk.
- Write addr 0x10 data 0xAB, then addr 0x11 data 0x03 → value_a=10'h2AF; busy never rises.
- Write addr 0x6B data 0x45 → up_tl=1, op=1, ch=3, d_in=0x45, busy=1. Model reg_busy rising 32 cen later → still held. reg_busy falls → strobe and busy 0 on that cen edge.
- While busy, write addr 0x28 data 0x7F → dropped; d_in stays 0x45 and up_kc stays 0. After IDLE, the same write is accepted.
- Write 0x14 data 0x35 → clr_flag_b and clr_flag_a each 1 for one clk; irqen_a=1, load_a=1, load_b=0, csm=0.
- With flag_a=1, flag_b=0 and a pending write → dout=8'h81. Holding wr_n low for 10 clk produces one event only.
